// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: parametrised AXI4-Lite memory target with byte strobes,
// address decode (DECERR out of window, SLVERR misaligned) and independent
// read and write paths, each allowing one outstanding transaction.
//
// Optional feature: define AXIL_ERR_CNT_EN to add ERR_COUNT, a saturating
// 16-bit count of error responses accepted on the B and R channels.
//
// Handshake rule for every channel: a beat transfers on a rising ACLK edge
// where VALID && READY are both high; BVALID/RVALID and their payloads are
// held unchanged until the matching READY is seen.
module axi_lite_mem_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RVALID,
   input  logic                    RREADY,
`ifdef AXIL_ERR_CNT_EN
   output logic [15:0]             ERR_COUNT,
`endif
   // [2:1] write state (0 idle, 1 addr held, 2 data held, 3 resp)
   // [0]   read state  (0 idle, 1 data)
   output logic [2:0]              dbg_state
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'(BYTES);
   localparam logic [63:0] BASE64 = 64'(BASE_ADDR);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state;
   r_state_t r_state;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Window check first, then alignment; BASE_ADDR is window aligned so the
   // raw address alignment equals the offset alignment.
   function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      logic [63:0] a;
      a = 64'(addr);
      if (a < BASE64 || (a - BASE64) >= SPAN)
         decode = RESP_DECERR;
      else if ((a & 64'(BYTES - 1)) != 64'd0)
         decode = RESP_SLVERR;
      else
         decode = RESP_OKAY;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      logic [63:0] off;
      off = 64'(addr) - BASE64;
      word_idx = IDX_W'(off >> LSB);
   endfunction

   logic                    aw_hs, w_hs, ar_hs;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [BYTES-1:0]        w_strb_q;
   logic                    commit;
   logic [ADDR_WIDTH-1:0]   c_addr;
   logic [DATA_WIDTH-1:0]   c_data;
   logic [BYTES-1:0]        c_strb;
   logic [1:0]              c_resp;
   logic [IDX_W-1:0]        c_idx;
   logic [1:0]              r_resp;
   logic [IDX_W-1:0]        r_idx;

   assign aw_hs  = AWVALID && AWREADY;
   assign w_hs   = WVALID && WREADY;
   assign ar_hs  = ARVALID && ARREADY;
   assign c_resp = decode(c_addr);
   assign c_idx  = word_idx(c_addr);
   assign r_resp = decode(ARADDR);
   assign r_idx  = word_idx(ARADDR);

   assign dbg_state = {w_state, r_state};

   // Commit edge detection: pick address/data from the live bus or the held copy.
   always_comb begin
      commit = 1'b0;
      c_addr = aw_addr_q;
      c_data = w_data_q;
      c_strb = w_strb_q;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
               c_addr = AWADDR;
               c_data = WDATA;
               c_strb = WSTRB;
            end
         end
         W_ADDR_HELD: begin
            if (w_hs) begin
               commit = 1'b1;
               c_data = WDATA;
               c_strb = WSTRB;
            end
         end
         W_DATA_HELD: begin
            if (aw_hs) begin
               commit = 1'b1;
               c_addr = AWADDR;
            end
         end
         default: ;
      endcase
   end

   // Write FSM: collect AW and W in either order, respond on B.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state <= W_IDLE;
         AWREADY <= 1'b1;
         WREADY  <= 1'b1;
         BVALID  <= 1'b0;
         BRESP   <= RESP_OKAY;
      end else if (commit) begin
         BRESP   <= c_resp;
         BVALID  <= 1'b1;
         AWREADY <= 1'b0;
         WREADY  <= 1'b0;
         w_state <= W_RESP;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_addr_q <= AWADDR;
                  AWREADY   <= 1'b0;
                  w_state   <= W_ADDR_HELD;
               end else if (w_hs) begin
                  w_data_q <= WDATA;
                  w_strb_q <= WSTRB;
                  WREADY   <= 1'b0;
                  w_state  <= W_DATA_HELD;
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  BVALID  <= 1'b0;
                  AWREADY <= 1'b1;
                  WREADY  <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Byte-lane memory write on an OKAY commit; errors never touch storage.
   always_ff @(posedge ACLK) begin
      if (!ARESET && commit && c_resp == RESP_OKAY) begin
         for (int b = 0; b < BYTES; b++) begin
            if (c_strb[b])
               mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
         end
      end
   end

   // Read FSM: sample memory on AR (pre-write value on a same-edge commit).
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= R_IDLE;
         ARREADY <= 1'b1;
         RVALID  <= 1'b0;
         RRESP   <= RESP_OKAY;
         RDATA   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  RRESP   <= r_resp;
                  RDATA   <= (r_resp == RESP_OKAY) ? mem[r_idx] : '0;
                  RVALID  <= 1'b1;
                  ARREADY <= 1'b0;
                  r_state <= R_DATA;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  RVALID  <= 1'b0;
                  ARREADY <= 1'b1;
                  r_state <= R_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AXIL_ERR_CNT_EN
   logic        b_err, r_err;
   logic [16:0] err_sum;

   assign b_err   = BVALID && BREADY && (BRESP != RESP_OKAY);
   assign r_err   = RVALID && RREADY && (RRESP != RESP_OKAY);
   assign err_sum = {1'b0, ERR_COUNT} + {16'd0, b_err} + {16'd0, r_err};

   // Saturating count of error responses accepted by the master.
   always_ff @(posedge ACLK) begin
      if (ARESET)
         ERR_COUNT <= 16'd0;
      else
         ERR_COUNT <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: directed scenarios plus randomized traffic checked
// against a word-array reference model of the memory target.
module tb_axi_lite_mem_slave;

   localparam int          AW    = 32;
   localparam int          DW    = 32;
   localparam int          DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h0;

   logic          ACLK, ARESET;
   logic [AW-1:0] AWADDR, ARADDR;
   logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [DW-1:0] WDATA, RDATA;
   logic [3:0]    WSTRB;
   logic [1:0]    BRESP, RRESP;
   logic          ARVALID, ARREADY, RVALID, RREADY;
   logic [2:0]    dbg_state;
`ifdef AXIL_ERR_CNT_EN
   logic [15:0]   ERR_COUNT;
`endif

   axi_lite_mem_slave #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
`ifdef AXIL_ERR_CNT_EN
      .ERR_COUNT(ERR_COUNT),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_pass   = 0;
   int          exp_err  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] ref_mem [0:DEPTH-1];
   logic [1:0]  pend_bresp, pend_rresp;
   logic [31:0] pend_rdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference decode straight from the address map.
   function automatic logic [1:0] model_resp(input logic [31:0] addr);
      longint unsigned a;
      a = {32'd0, addr};
      if (a < BASE || a >= longint'(BASE) + DEPTH * 4) return 2'b11;
      if (a % 4 != 0) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      if (model_resp(addr) != 2'b00) return;
      idx = int'((addr - BASE) / 4);
      for (int b = 0; b < 4; b++)
         if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      if (model_resp(addr) != 2'b00) return 32'h0;
      return ref_mem[int'((addr - BASE) / 4)];
   endfunction

   // ---------------- driver tasks ----------------
   // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap = idle cycles between.
   task automatic write_issue(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int order, input int gap);
      logic [1:0] exp;
      exp = model_resp(addr);
      check("aw_ready_idle", {AWREADY, WREADY}, 2'b11);
      AWADDR = addr; WDATA = data; WSTRB = strb;
      if (order == 0) begin
         AWVALID = 1'b1; WVALID = 1'b1;
         @(negedge ACLK);
         AWVALID = 1'b0; WVALID = 1'b0;
      end else if (order == 1) begin
         AWVALID = 1'b1;
         @(negedge ACLK);
         AWVALID = 1'b0;
         check("aw_ready_drop", {AWREADY, WREADY}, 2'b01);
         repeat (gap) begin
            @(negedge ACLK);
            check("b_early_aw", BVALID, 1'b0);
         end
         WVALID = 1'b1;
         @(negedge ACLK);
         WVALID = 1'b0;
      end else begin
         WVALID = 1'b1;
         @(negedge ACLK);
         WVALID = 1'b0;
         check("w_ready_drop", {AWREADY, WREADY}, 2'b10);
         repeat (gap) begin
            @(negedge ACLK);
            check("b_early_w", BVALID, 1'b0);
         end
         AWVALID = 1'b1;
         @(negedge ACLK);
         AWVALID = 1'b0;
      end
      check("bvalid_lat", BVALID, 1'b1);
      check("bresp", BRESP, exp);
      check("w_busy", {AWREADY, WREADY}, 2'b00);
      model_write(addr, data, strb);
      pend_bresp = exp;
   endtask

   task automatic write_accept(input int bdelay);
      repeat (bdelay) begin
         @(negedge ACLK);
         check("b_hold", {BVALID, BRESP, AWREADY, WREADY}, {1'b1, pend_bresp, 2'b00});
      end
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      if (pend_bresp != 2'b00) exp_err++;
      check("b_done", {BVALID, AWREADY, WREADY}, 3'b011);
   endtask

   task automatic read_issue(input logic [31:0] addr);
      logic [31:0] e;
      pend_rresp = model_resp(addr);
      exp_q.push_back(model_read(addr));
      check("ar_ready_idle", ARREADY, 1'b1);
      ARADDR = addr; ARVALID = 1'b1;
      @(negedge ACLK);
      ARVALID = 1'b0;
      e = exp_q.pop_front();
      pend_rdata = e;
      check("rvalid_lat", RVALID, 1'b1);
      check("rresp", RRESP, pend_rresp);
      check("rdata", RDATA, e);
      check("ar_busy", ARREADY, 1'b0);
   endtask

   task automatic read_accept(input int rdelay);
      repeat (rdelay) begin
         @(negedge ACLK);
         check("r_hold", {RVALID, RRESP, RDATA}, {1'b1, pend_rresp, pend_rdata});
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
      if (pend_rresp != 2'b00) exp_err++;
      check("r_done", {RVALID, ARREADY}, 2'b01);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int gap, input int bdelay);
      write_issue(addr, data, strb, order, gap);
      write_accept(bdelay);
   endtask

   task automatic do_read(input logic [31:0] addr, input int rdelay);
      read_issue(addr);
      read_accept(rdelay);
   endtask

   // Write commit and AR handshake on one edge; both responses accepted on one edge.
   task automatic rw_same_edge(input logic [31:0] waddr, input logic [31:0] wdata, input logic [31:0] raddr);
      logic [1:0]  wr, rr;
      logic [31:0] e;
      wr = model_resp(waddr);
      rr = model_resp(raddr);
      exp_q.push_back(model_read(raddr));
      AWADDR = waddr; WDATA = wdata; WSTRB = 4'hF; ARADDR = raddr;
      AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      model_write(waddr, wdata, 4'hF);
      e = exp_q.pop_front();
      check("same_b", {BVALID, BRESP}, {1'b1, wr});
      check("same_r", {RVALID, RRESP}, {1'b1, rr});
      check("same_rdata", RDATA, e);
      BREADY = 1'b1; RREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0; RREADY = 1'b0;
      if (wr != 2'b00) exp_err++;
      if (rr != 2'b00) exp_err++;
      check("same_done", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
   endtask

   function automatic logic [31:0] rand_addr();
      int k;
      k = $urandom_range(0, 99);
      if (k < 70) return 32'($urandom_range(0, 15) * 4);
      if (k < 85) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      if (k < 95) return 32'h4000 + 32'($urandom_range(0, 255) * 4);
      return 32'hFFFF_FF00 + 32'($urandom_range(0, 63) * 4);
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      ARESET = 1'b1;
      AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
      repeat (3) @(negedge ACLK);
      check("rst_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 9'b111_00_0000);
      check("rst_rdata", RDATA, 32'h0);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rst_state", dbg_state, 3'b000);

      // Known contents for the traffic region 0x00..0x3C.
      for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom(), 4'hF, 0, 0, 0);

      // Decode errors: out-of-window write must not alias onto word 0.
      do_write(32'h4000, 32'h1234_5678, 4'hF, 0, 0, 1);
      do_read(32'h0, 0);
      do_read(32'h6, 0);
`ifdef AXIL_ERR_CNT_EN
      check("err_count_2", ERR_COUNT, 16'd2);
`endif

      // Aligned write then read.
      do_write(32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      do_read(32'h14, 0);

      // Partial strobe.
      do_write(32'h4, 32'h1122_3344, 4'hF, 0, 0, 0);
      do_write(32'h4, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
      do_read(32'h4, 0);
      do_write(32'hC, 32'hCAFE_F00D, 4'h0, 1, 1, 0);
      do_read(32'hC, 0);

      // W before AW, then AW before W.
      do_write(32'h8, 32'h55, 4'hF, 2, 2, 0);
      do_read(32'h8, 0);
      do_write(32'h10, 32'h0BAD_F00D, 4'hF, 1, 3, 2);
      do_read(32'h10, 1);

      // B back-pressure while the read channel runs.
      write_issue(32'h2C, 32'h600D_CAFE, 4'hF, 0, 0);
      read_issue(32'h2C);
      check("bp_b_stable", {BVALID, BRESP, AWREADY}, 4'b1_00_0);
      read_accept(1);
      check("bp_b_stable2", {BVALID, BRESP, AWREADY}, 4'b1_00_0);
      write_accept(2);

      // Same-edge read/write: pre-write data, then new data.
      rw_same_edge(32'h18, 32'h7777_1111, 32'h18);
      do_read(32'h18, 0);
      rw_same_edge(32'h4004, 32'h0, 32'h3);

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 1) == 0)
            do_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(rand_addr(), $urandom_range(0, 3));
      end
`ifdef AXIL_ERR_CNT_EN
      check("err_count_rand", ERR_COUNT, 16'(exp_err));
`endif

      // Reset with write in address-held and read in data phase.
      AWADDR = 32'h20; AWVALID = 1'b1; ARADDR = 32'h24; ARVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; ARVALID = 1'b0;
      check("mid_state", dbg_state, 3'b011);
      check("mid_flags", {AWREADY, WREADY, RVALID}, 3'b011);
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      exp_err = 0;
      check("rst_mid", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
      check("rst_mid_state", dbg_state, 3'b000);
`ifdef AXIL_ERR_CNT_EN
      check("rst_err_count", ERR_COUNT, 16'd0);
`endif
      do_write(32'h20, 32'h1357_9BDF, 4'hF, 1, 0, 0);
      do_read(32'h20, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
